// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the sequential ALU and its multiplier.
// The opcodes 0-5 keep the encoding used by the original combinational ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_PASS = 3'd2;
    localparam logic [2:0] OP_ZER  = 3'd3;
    localparam logic [2:0] OP_MUL  = 3'd4;
    localparam logic [2:0] OP_SHL  = 3'd5;
    localparam logic [2:0] OP_MAC  = 3'd6;
    localparam logic [2:0] OP_ACLR = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MRUN = 2'd1,
        S_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle,
// WIDTH steps after start, full 2*WIDTH product held until the next start.
module seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] product_reg;
    logic [CW-1:0]      count_reg;

    // The multiplicand is pre-shifted one place per step, so at each step it
    // already equals multiplicand << (WIDTH - count).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            product_reg <= '0;
            count_reg   <= '0;
        end else if (start) begin
            mcand_reg   <= {{WIDTH{1'b0}}, a};
            mplier_reg  <= b;
            product_reg <= '0;
            count_reg   <= CW'(WIDTH);
        end else if (count_reg != '0) begin
            if (mplier_reg[0]) begin
                product_reg <= product_reg + mcand_reg;
            end
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg - CW'(1);
        end
    end

    // Asserted during the final step; the product is complete after this edge.
    assign done    = (count_reg == CW'(1));
    assign product = product_reg;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with registered result/flags behind valid/ready, an
// iterative multiplier for MUL/MAC and a multiply-accumulate register.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32,
    parameter int SHW       = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           alu_op,
    input  logic [WIDTH-1:0]     a_bus,
    input  logic [WIDTH-1:0]     b_bus,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     c_bus,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic [ACC_WIDTH-1:0] acc_out
);

    localparam logic [WIDTH-1:0] WIDTH_W = WIDTH[WIDTH-1:0];

    state_t               state_reg;
    logic [2:0]           op_reg;
    logic [WIDTH-1:0]     c_reg;
    logic                 z_reg;
    logic                 cf_reg;
    logic                 out_valid_reg;
    logic [ACC_WIDTH-1:0] acc_reg;

    logic                 accept;
    logic                 consume;
    logic                 is_long;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    logic [WIDTH:0]       add_full;
    logic [WIDTH:0]       sub_full;
    logic [2*WIDTH-1:0]   shl_full;
    logic [WIDTH-1:0]     short_c;
    logic                 short_cf;

    logic [ACC_WIDTH:0]   mac_sum;
    logic [WIDTH-1:0]     fin_c;
    logic                 fin_cf;

    assign in_ready = (state_reg == S_IDLE) && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_reg && out_ready;
    assign is_long  = (alu_op == OP_MUL) || (alu_op == OP_MAC);

    seq_mul #(
        .WIDTH(WIDTH)
    ) u_seq_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_long),
        .a       (a_bus),
        .b       (b_bus),
        .done    (mul_done),
        .product (mul_product)
    );

    assign add_full = {1'b0, a_bus} + {1'b0, b_bus};
    assign sub_full = {1'b0, a_bus} - {1'b0, b_bus};
    assign shl_full = {{WIDTH{1'b0}}, a_bus} << b_bus[SHW-1:0];

    always_comb begin
        short_c  = '0;
        short_cf = 1'b0;
        case (alu_op)
            OP_ADD: begin
                short_c  = add_full[WIDTH-1:0];
                short_cf = add_full[WIDTH];
            end
            OP_SUB: begin
                short_c  = sub_full[WIDTH-1:0];
                short_cf = sub_full[WIDTH];
            end
            OP_PASS: short_c = b_bus;
            OP_SHL: begin
                // Shifting by WIDTH or more pushes every set bit of A out.
                if (b_bus >= WIDTH_W) begin
                    short_cf = |a_bus;
                end else begin
                    short_c  = shl_full[WIDTH-1:0];
                    short_cf = |shl_full[2*WIDTH-1:WIDTH];
                end
            end
            default: begin
                short_c  = '0;
                short_cf = 1'b0;
            end
        endcase
    end

    assign mac_sum = {1'b0, acc_reg}
                   + {{(ACC_WIDTH + 1 - 2*WIDTH){1'b0}}, mul_product};
    assign fin_c   = (op_reg == OP_MAC) ? mac_sum[WIDTH-1:0] : mul_product[WIDTH-1:0];
    assign fin_cf  = (op_reg == OP_MAC) ? mac_sum[ACC_WIDTH]
                                        : |mul_product[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            op_reg        <= '0;
            c_reg         <= '0;
            z_reg         <= 1'b0;
            cf_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
            acc_reg       <= '0;
        end else begin
            // A new result written below overrides this drop.
            if (consume) begin
                out_valid_reg <= 1'b0;
            end
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        op_reg <= alu_op;
                        if (is_long) begin
                            state_reg <= S_MRUN;
                        end else begin
                            c_reg         <= short_c;
                            z_reg         <= (short_c == '0);
                            cf_reg        <= short_cf;
                            out_valid_reg <= 1'b1;
                            if (alu_op == OP_ACLR) begin
                                acc_reg <= '0;
                            end
                        end
                    end
                end
                S_MRUN: begin
                    if (mul_done) begin
                        state_reg <= S_FIN;
                    end
                end
                S_FIN: begin
                    if (!out_valid_reg || out_ready) begin
                        c_reg         <= fin_c;
                        z_reg         <= (fin_c == '0);
                        cf_reg        <= fin_cf;
                        out_valid_reg <= 1'b1;
                        state_reg     <= S_IDLE;
                        if (op_reg == OP_MAC) begin
                            acc_reg <= mac_sum[ACC_WIDTH-1:0];
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign c_bus     = c_reg;
    assign flag_z    = z_reg;
    assign flag_c    = cf_reg;
    assign acc_out   = acc_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: hand-computed results, latencies,
// backpressure stability and asynchronous reset in the middle of a multiply.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_op;
    logic [15:0] a_bus;
    logic [15:0] b_bus;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] c_bus;
    logic        flag_z;
    logic        flag_c;
    logic [31:0] acc_out;

    int tests = 0;
    int fails = 0;
    int cyc;
    int low_cnt;

    always #5 clk = ~clk;

    alu_seq #(
        .WIDTH     (16),
        .ACC_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_bus     (c_bus),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .acc_out   (acc_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input string name);
        $display("[TB] %s a=%h b=%h -> c=%h z=%b c=%b valid=%b acc=%h",
                 name, a_bus, b_bus, c_bus, flag_z, flag_c, out_valid, acc_out);
    endtask

    // Presents one request for one accepting edge; returns #1 after that edge.
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        alu_op   = op;
        a_bus    = a;
        b_bus    = b;
        chk("in_ready_at_issue", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    // Issues a MUL/MAC and waits (bounded) for out_valid; cyc = cycles after acceptance.
    task automatic run_long(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        issue(op, a, b);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        alu_op    = 3'd0;
        a_bus     = '0;
        b_bus     = '0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_c_bus", c_bus, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags", {flag_z, flag_c}, 0);
        chk("rst_acc", acc_out, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        step();

        issue(3'd0, 16'hFFFF, 16'h0001);
        show("ADD");
        chk("add_c", c_bus, 16'h0000);
        chk("add_zc", {flag_z, flag_c}, 2'b11);
        chk("add_valid", out_valid, 1);

        issue(3'd1, 16'd3, 16'd5);
        show("SUB");
        chk("sub_c", c_bus, 16'hFFFE);
        chk("sub_zc", {flag_z, flag_c}, 2'b01);

        issue(3'd2, 16'h1234, 16'h0000);
        show("PASS");
        chk("pass_c", c_bus, 16'h0000);
        chk("pass_zc", {flag_z, flag_c}, 2'b10);

        issue(3'd3, 16'h1234, 16'h5678);
        show("ZER");
        chk("zer_c", c_bus, 16'h0000);
        chk("zer_zc", {flag_z, flag_c}, 2'b10);

        // MUL: in_ready low cycles 1..17, out_valid first seen at cycle 18.
        issue(3'd4, 16'd300, 16'd300);
        cyc = 1;
        low_cnt = 0;
        while (!out_valid && cyc < 40) begin
            if (!in_ready) low_cnt++;
            step();
            cyc++;
        end
        show("MUL");
        chk("mul_latency", cyc, 18);
        chk("mul_busy_cycles", low_cnt, 17);
        chk("mul_c", c_bus, 16'h5F90);
        chk("mul_zc", {flag_z, flag_c}, 2'b01);

        issue(3'd7, 16'h0000, 16'h0000);
        show("ACLR");
        chk("aclr_acc", acc_out, 0);
        chk("aclr_zc", {flag_z, flag_c}, 2'b10);

        run_long(3'd6, 16'd2, 16'd3);
        show("MAC");
        chk("mac1_latency", cyc, 18);
        chk("mac1_acc", acc_out, 32'd6);
        chk("mac1_c", c_bus, 16'd6);
        run_long(3'd6, 16'd4, 16'd5);
        show("MAC");
        chk("mac2_acc", acc_out, 32'd26);
        run_long(3'd6, 16'hFFFF, 16'hFFFF);
        show("MAC");
        chk("mac3_acc", acc_out, 32'hFFFE001B);
        chk("mac3_c", c_bus, 16'h001B);
        chk("mac3_zc", {flag_z, flag_c}, 2'b00);
        run_long(3'd6, 16'hFFFF, 16'hFFFF);
        show("MAC");
        chk("mac_wrap_acc", acc_out, 32'hFFFC001C);
        chk("mac_wrap_c", c_bus, 16'h001C);
        chk("mac_wrap_flag_c", flag_c, 1);

        // ACLR accepted in the same cycle the MAC result is consumed.
        issue(3'd7, 16'h0000, 16'h0000);
        show("ACLR");
        chk("aclr_consume_acc", acc_out, 0);
        chk("aclr_consume_valid", out_valid, 1);

        issue(3'd5, 16'h8001, 16'd1);
        show("SHL");
        chk("shl1_c", c_bus, 16'h0002);
        chk("shl1_zc", {flag_z, flag_c}, 2'b01);
        issue(3'd5, 16'h8001, 16'd16);
        show("SHL");
        chk("shl16_c", c_bus, 16'h0000);
        chk("shl16_zc", {flag_z, flag_c}, 2'b11);
        issue(3'd5, 16'h0001, 16'd15);
        show("SHL");
        chk("shl15_c", c_bus, 16'h8000);
        chk("shl15_zc", {flag_z, flag_c}, 2'b00);

        // Backpressure: result held, new requests refused.
        issue(3'd0, 16'd5, 16'd6);
        out_ready = 1'b0;
        show("ADD");
        chk("bp_c", c_bus, 16'h000B);
        in_valid = 1'b1;
        alu_op   = 3'd0;
        a_bus    = 16'd1;
        b_bus    = 16'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_c", c_bus, 16'h000B);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_drain_valid", out_valid, 0);

        // Reset asserted during a multiply.
        run_long(3'd6, 16'd2, 16'd3);
        show("MAC");
        chk("pre_rst_acc", acc_out, 32'd6);
        issue(3'd4, 16'd300, 16'd300);
        for (int i = 0; i < 4; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        $display("[TB] RESET mid-MUL -> c=%h z=%b c=%b valid=%b acc=%h",
                 c_bus, flag_z, flag_c, out_valid, acc_out);
        chk("midrst_c", c_bus, 0);
        chk("midrst_flags", {flag_z, flag_c}, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_acc", acc_out, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_valid", out_valid, 0);
        run_long(3'd4, 16'd7, 16'd9);
        show("MUL");
        chk("post_rst_mul_c", c_bus, 16'd63);
        chk("post_rst_mul_zc", {flag_z, flag_c}, 2'b00);
        issue(3'd0, 16'd2, 16'd2);
        show("ADD");
        chk("post_rst_add_c", c_bus, 16'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the datapath ALU for the matrix-multiplication processor.
- Registered result and flags behind a valid/ready handshake.
- Iterative shift-add multiplier, so MUL no longer forms a full combinational multiply.
- Accumulator with multiply-accumulate (MAC), so the control unit can compute dot products without routing partial sums through the register file.

Parameters:
- WIDTH, 16, operand and result width (must be ≥ 4).
- ACC_WIDTH, 32, accumulator width (must be ≥ 2*WIDTH).
- SHW, $clog2(WIDTH), number of shift-amount bits taken from B (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- alu_op  in  3  opcode.
- a_bus  in  WIDTH  operand A.
- b_bus  in  WIDTH  operand B.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- c_bus  out  WIDTH  result.
- flag_z  out  1  result zero.
- flag_c  out  1  carry/borrow/overflow.
- acc_out  out  ACC_WIDTH  current accumulator value.

Behaviour:
- Reset (asynchronous, any time, including mid-multiply):
  - State returns to IDLE.
  - c_bus, flag_z, flag_c, out_valid, acc_out and all multiplier registers go to 0.
  - in_ready is 1 after reset.
- Opcodes (codes 0–5 match the existing ALU encoding):
  - 0 ADD: c = A+B; flag_c = carry-out.
  - 1 SUB: c = A−B; flag_c = borrow (A<B unsigned).
  - 2 PASS: c = B; flag_c = 0.
  - 3 ZER: c = 0; flag_c = 0.
  - 4 MUL: c = low WIDTH bits of A*B (unsigned); flag_c = 1 if the high WIDTH bits are nonzero.
  - 5 SHL: c = A << B[SHW-1:0] when B < WIDTH. When B ≥ WIDTH, c = 0. flag_c = 1 if any 1-bit is shifted out.
  - 6 MAC: acc ← acc + zero-extended full 2*WIDTH product, modulo 2^ACC_WIDTH. c = low WIDTH bits of the new acc. flag_c = 1 if the accumulator wrapped.
  - 7 ACLR: acc ← 0; c = 0; flag_c = 0.
- flag_z = (c == 0) for every opcode, all registered. No flag ever holds a stale value.
- Handshake:
  - in_ready = (state == IDLE) && (!out_valid || out_ready).
  - A request is accepted when in_valid && in_ready. The operands and opcode are captured that cycle.
  - A result is consumed when out_valid && out_ready. With no new result, out_valid drops the next cycle.
  - c_bus, flag_z, flag_c are stable while out_valid && !out_ready.
- State machine:
  - IDLE: accept ADD/SUB/PASS/ZER/SHL/ACLR → result registered on the next edge. out_valid = 1 one cycle after acceptance (latency 1, back-to-back throughput 1/cycle).
  - IDLE: accept MUL/MAC → go to MRUN; load multiplicand, multiplier, product = 0, count = WIDTH.
  - MRUN: each cycle, if multiplier LSB = 1, product += multiplicand << (WIDTH − count). Then shift the multiplier right and decrement count. in_ready = 0 throughout.
  - When count reaches 0 → FIN.
  - FIN: write the result and flags (and acc for MAC) → IDLE with out_valid = 1. MUL/MAC latency is WIDTH + 2 cycles from acceptance to out_valid.
  - FIN may not write while the output register holds an unconsumed result. It stalls in FIN until out_ready.
- Boundary cases:
  - ACLR or MAC accepted in the same cycle as a consume: both occur.
  - acc_out updates on the same edge as c_bus.
  - Illegal states decode to IDLE.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD … OP_ACLR);
  - state encoding (S_IDLE, S_MRUN, S_FIN).
- One natural sub-module: seq_mul, the iterative shift-add multiplier with WIDTH parameter and start/done interface, returning a 2*WIDTH product.
- The accumulator, flags and handshake stay in alu_seq.

Test Plan:
- Reset, then ADD A=16'hFFFF B=16'h0001, out_ready=1 → one cycle later c=0, flag_z=1, flag_c=1, out_valid=1.
- SUB A=3 B=5 → c=16'hFFFE, flag_c=1, flag_z=0. Then PASS B=0 → c=0, flag_z=1, flag_c=0.
- MUL A=300 B=300 → in_ready low for 17 cycles, out_valid at cycle 18. c=16'h5F90, flag_c=1 (90000 = 0x15F90).
- MAC sequence:
  - ACLR, then MAC(2,3), MAC(4,5), MAC(16'hFFFF,16'hFFFF) → acc_out = 6, 26, 0xFFFE001B; final flag_c=0.
  - Then preload acc near 2^32 via repeated MAC → wrap sets flag_c=1.
- SHL A=16'h8001 B=1 → c=16'h0002, flag_c=1. B=16 → c=0, flag_z=1, flag_c=1.
- Backpressure and mid-operation reset:
  - Hold out_ready=0 after ADD: c_bus stays stable and in_ready=0.
  - Start MUL, assert rst_n=0 at cycle 5 → all outputs 0 immediately, in_ready=1 after release.
